// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives memory read port 0 and buffers {instr, pc} for decode.
// Define FETCH_BYPASS_EN to present a freshly fetched word in the same cycle when the queue is empty.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              mem_raddr,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_busy,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          not_empty;
    logic          full;
    logic          pop;
    logic          fetch;
    logic          push;
    logic          bypass_hit;
    logic          bypass_take;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = not_empty && out_ready && !redirect_valid;
    // Pop only comes from stored entries, so a full queue can refill in the cycle it drains.
    assign fetch     = rst && !mem_busy && !redirect_valid && (!full || pop);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = fetch && !not_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign bypass_take = bypass_hit && out_ready;
    assign push        = fetch && !bypass_take;
    assign mem_raddr   = fetch_pc;
    assign out_valid   = !redirect_valid && (not_empty || bypass_hit);

    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            if (not_empty) begin
                out_instr = instr_q[rd_ptr];
                out_pc    = pc_q[rd_ptr];
            end else begin
                out_instr = mem_rdata;
                out_pc    = fetch_pc;
            end
        end
    end

    // Redirect wins over everything; flushed entries stay in the array but are never exposed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (fetch) begin
                fetch_pc <= fetch_pc + 32'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

endmodule
